// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the round datapath.
// Byte i of a state is bits [(15-i)*8 +: 8]; the state is column-major.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  localparam logic [7:0] AES_POLY = 8'h1B;

  // Output byte i of forward ShiftRows takes input byte SR_FWD_IDX[i]; the inverse stage derives its table from this one.
  localparam logic [3:0] SR_FWD_IDX [16] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [AES_STATE_W-1:0] shift_rows_fwd(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src = int'(SR_FWD_IDX[i]);
      r[(15-i)*8 +: 8] = s[(15-src)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// MixColumns on one 32-bit column, row 0 in the most-significant byte.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a = xtime(a) ^ a
  assign mixed[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign mixed[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign mixed[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign mixed[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/shift_rows_mix_stage.sv
// Forward AES ShiftRows + optional MixColumns, followed by a 2-entry output FIFO.
// Handshake: a beat moves when valid && ready on the same rising edge; in_ready depends only on stored count.
module shift_rows_mix_stage
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_STATE_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mixed;
  logic [DATA_W-1:0] transformed;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_last [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign shifted = shift_rows_fwd(data_in);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_column_word u_mix (
      .col   (shifted[c*32 +: 32]),
      .mixed (mixed[c*32 +: 32])
    );
  end

  assign transformed = in_last ? shifted : mixed;

  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Gating on out_valid keeps outputs at zero after reset without resetting storage.
  assign data_out = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= transformed;
      mem_last[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_mix_stage.sv
// Bench for shift_rows_mix_stage: directed vectors plus random traffic against a byte-level AES model.
module tb_shift_rows_mix_stage;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [127:0] data_out;

  logic [128:0] exp_q[$];
  int n_checks;
  int n_fail;
  int pop_count;

  shift_rows_mix_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .data_out  (data_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d, input logic last);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) s[i] = d[(15-i)*8 +: 8];
    for (int i = 0; i < 16; i++) t[i] = s[(((i/4) + (i%4)) % 4) * 4 + (i%4)];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        u[c*4+row] = gmul(8'h02, t[c*4+row]) ^ gmul(8'h03, t[c*4+(row+1)%4])
                   ^ t[c*4+(row+2)%4] ^ t[c*4+(row+3)%4];
    r = '0;
    for (int i = 0; i < 16; i++) r[(15-i)*8 +: 8] = last ? t[i] : u[i];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      logic [128:0] e;
      n_checks++;
      pop_count++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got last=%0b data=%h, none expected", out_last, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, data_out} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got last=%0b data=%h, expected last=%0b data=%h",
                   out_last, data_out, e[128], e[127:0]);
        end
      end
    end
  end

  // drivers
  task automatic drive(input logic [127:0] d, input logic l, output int waits);
    bit accepted;
    accepted = 0;
    waits = 0;
    in_valid = 1'b1; data_in = d; in_last = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({l, ref_model(d, l)});
        accepted = 1;
        break;
      end
      waits++;
    end
    if (!accepted) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    data_in = 'x;
    in_last = 1'b0;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int t = 0; t < budget && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats left, expected 0", exp_q.size());
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; data_in = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, out_last} !== 3'b100 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b out_last=%0b data_out=%h, expected 1 0 0 0",
               in_ready, out_valid, out_last, data_out);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_shift_rows();
    int w;
    out_ready = 1'b1;
    drive(128'h000102030405060708090a0b0c0d0e0f, 1'b1, w);
    go_idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || data_out !== 128'h00050a0f04090e03080d02070c01060b) begin
      n_fail++;
      $display("FAIL shift_rows: valid=%0b last=%0b data=%h, expected 1 1 00050a0f04090e03080d02070c01060b",
               out_valid, out_last, data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fips_round();
    int w;
    out_ready = 1'b1;
    drive(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, w);
    go_idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b0 || data_out !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
      n_fail++;
      $display("FAIL fips_round: valid=%0b last=%0b data=%h, expected 1 0 046681e5e0cb199a48f8d37a2806264c",
               out_valid, out_last, data_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, c;
    logic [127:0] a_exp;
    int w;
    a = rand_state(); b = rand_state(); c = rand_state();
    a_exp = ref_model(a, 1'b0);
    out_ready = 1'b0;
    drive(a, 1'b0, w);
    drive(b, 1'b1, w);
    in_valid = 1'b1; data_in = c; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== a_exp || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold: in_ready=%0b valid=%0b last=%0b data=%h, expected 0 1 0 %h",
                 in_ready, out_valid, out_last, data_out, a_exp);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(c, 1'b0, w);
    n_checks++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL backpressure_release: C waited %0d cycles, expected 1", w);
    end
    go_idle();
    drain(10);
  endtask

  task automatic test_streaming();
    int w;
    int stalls;
    int start_pops;
    stalls = 0;
    out_ready = 1'b1;
    start_pops = pop_count;
    for (int k = 0; k < 16; k++) begin
      drive(rand_state(), 1'($urandom_range(0, 1)), w);
      stalls += w;
    end
    go_idle();
    @(posedge clk); #1;
    n_checks++;
    if (stalls != 0 || pop_count - start_pops != 16) begin
      n_fail++;
      $display("FAIL streaming: stalls=%0d beats_out=%0d, expected 0 16", stalls, pop_count - start_pops);
    end
    drain(5);
  endtask

  task automatic test_random_traffic();
    int start_pops;
    bit done;
    done = 0;
    start_pops = pop_count;
    fork
      begin
        int w;
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(0, 2)) begin
            go_idle();
            @(posedge clk); #1;
          end
          drive(rand_state(), 1'($urandom_range(0, 3) == 0), w);
        end
        go_idle();
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 99) < 60);
          @(posedge clk); #1;
        end
      end
    join
    drain(20);
    n_checks++;
    if (pop_count - start_pops != 1000) begin
      n_fail++;
      $display("FAIL random_count: %0d beats out, expected 1000", pop_count - start_pops);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [127:0] d;
    int w;
    out_ready = 1'b0;
    drive(rand_state(), 1'b0, w);
    drive(rand_state(), 1'b1, w);
    go_idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_full: valid=%0b in_ready=%0b, expected 1 0", out_valid, in_ready);
    end
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: valid=%0b last=%0b data=%h, expected 0 0 0", out_valid, out_last, data_out);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: in_ready=%0b valid=%0b, expected 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    d = rand_state();
    drive(d, 1'b0, w);
    go_idle();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || data_out !== ref_model(d, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_mid_next: valid=%0b data=%h, expected 1 %h", out_valid, data_out, ref_model(d, 1'b0));
    end
    @(posedge clk); #1;
    drain(5);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    pop_count = 0;
    test_reset();
    test_shift_rows();
    test_fips_round();
    test_backpressure();
    test_streaming();
    test_random_traffic();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
